// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : uart_pkg                                                    |
// | Description: Shared constants, state encoding and baud divider helper    |
// |              for the buffered 8N1 UART transmitter.                      |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package uart_pkg;

   localparam int unsigned BAUD_9600   = 9600;
   localparam int unsigned BAUD_19200  = 19200;
   localparam int unsigned BAUD_38400  = 38400;
   localparam int unsigned BAUD_57600  = 57600;
   localparam int unsigned BAUD_115200 = 115200;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = S_IDLE,
      START = S_START,
      DATA  = S_DATA,
      STOP  = S_STOP
   } tx_state_t;

   // Clocks per bit minus one; unlisted selections fall back to 9600 baud.
   function automatic int unsigned baud_div(input int unsigned clk_freq,
                                            input logic [2:0]  baud_set);
      int unsigned baud;
      case (baud_set)
         3'd1:    baud = BAUD_19200;
         3'd2:    baud = BAUD_38400;
         3'd3:    baud = BAUD_57600;
         3'd4:    baud = BAUD_115200;
         default: baud = BAUD_9600;
      endcase
      return clk_freq / baud - 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : uart_sync_fifo                                              |
// | Description: Single-clock first-word-fall-through FIFO. rd_data always   |
// |              shows the head entry; rd_en consumes it.                    |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module uart_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = DEPTH[CNT_W-1:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             wr_accept;
   logic             rd_accept;

   // Flags come from the registered count so a write is judged against the
   // occupancy at the start of the cycle, regardless of a concurrent pop.
   assign full      = (count_q == FULL_CNT);
   assign empty     = (count_q == '0);
   assign wr_accept = wr_en && !full;
   assign rd_accept = rd_en && !empty;
   assign rd_data   = mem_q[rd_ptr_q];
   assign count     = count_q;

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_accept) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (rd_accept) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({wr_accept, rd_accept})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage array carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_buffered_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : uart_buffered_tx                                            |
// | Description: 8N1 UART transmitter fed from a byte FIFO; queued bytes are |
// |              sent back-to-back at a per-frame selectable baud rate.      |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module uart_buffered_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [2:0]                    baud_set,
   input  logic [7:0]                    wr_data,
   input  logic                          wr_en,
   output logic                          full,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          uart_tx,
   output logic                          tx_busy,
   output logic                          tx_done
);

   // 9600 baud is the slowest rate, so its divider sets the counter width.
   localparam int DIV_W = $clog2(CLK_FREQ / BAUD_9600);
   localparam int BIT_W = $clog2(DATA_BITS);
   localparam logic [DIV_W-1:0] DIV_0 = DIV_W'(baud_div(CLK_FREQ, 3'd0));
   localparam logic [DIV_W-1:0] DIV_1 = DIV_W'(baud_div(CLK_FREQ, 3'd1));
   localparam logic [DIV_W-1:0] DIV_2 = DIV_W'(baud_div(CLK_FREQ, 3'd2));
   localparam logic [DIV_W-1:0] DIV_3 = DIV_W'(baud_div(CLK_FREQ, 3'd3));
   localparam logic [DIV_W-1:0] DIV_4 = DIV_W'(baud_div(CLK_FREQ, 3'd4));
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

   tx_state_t        state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ovf_q, ovf_d;

   logic [DIV_W-1:0] div_sel;
   logic             bit_end;
   logic             pop;
   logic [7:0]       fifo_rd_data;
   logic             fifo_full;
   logic             fifo_empty;

   uart_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign bit_end = (cnt_q == div_q);

   // Divider lookup for the rate requested right now; latched at frame start.
   always_comb begin
      case (baud_set)
         3'd1:    div_sel = DIV_1;
         3'd2:    div_sel = DIV_2;
         3'd3:    div_sel = DIV_3;
         3'd4:    div_sel = DIV_4;
         default: div_sel = DIV_0;
      endcase
   end

   // Frame sequencing: baud counter, bit counter, shift register and pops.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      if (state_q != IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + DIV_W'(1);
      end
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_rd_data;
               div_d   = div_sel;
               bit_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == DATA_LAST) begin
                  bit_d   = '0;
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               if (bit_q != STOP_LAST) begin
                  bit_d = bit_q + BIT_W'(1);
               end else if (!fifo_empty) begin
                  // Chain straight into the next start bit with no idle gap.
                  pop     = 1'b1;
                  shift_d = fifo_rd_data;
                  div_d   = div_sel;
                  bit_d   = '0;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output values derived from the current state, registered one cycle later
   // so the line, busy and done stay mutually aligned.
   always_comb begin
      case (state_q)
         IDLE:    tx_d = 1'b1;
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_q[0];
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_q != IDLE);
      done_d = (state_q == STOP) && bit_end && (bit_q == STOP_LAST);
      ovf_d  = wr_en && fifo_full;
   end

   // State and output registers; reset forces the line idle immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= DIV_0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   assign full     = fifo_full;
   assign overflow = ovf_q;
   assign uart_tx  = tx_q;
   assign tx_busy  = busy_q;
   assign tx_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_buffered_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_uart_buffered_tx                                         |
// | Description: Directed self-checking bench for uart_buffered_tx at 50 MHz.|
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_uart_buffered_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] baud_set;
   logic [7:0] wr_data;
   logic       wr_en;
   logic       full;
   logic       overflow;
   logic [4:0] fifo_count;
   logic       uart_tx;
   logic       tx_busy;
   logic       tx_done;

   int n_assert = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int ovf_cnt  = 0;
   int d0;

   uart_buffered_tx #(
      .CLK_FREQ   (50_000_000),
      .FIFO_DEPTH (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .baud_set   (baud_set),
      .wr_data    (wr_data),
      .wr_en      (wr_en),
      .full       (full),
      .overflow   (overflow),
      .fifo_count (fifo_count),
      .uart_tx    (uart_tx),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done)
   );

   // 50 MHz clock.
   always #10 clk = ~clk;

   // Pulse counters for tx_done and overflow.
   always @(posedge clk) begin
      if (tx_done === 1'b1)  done_cnt <= done_cnt + 1;
      if (overflow === 1'b1) ovf_cnt  <= ovf_cnt + 1;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered on the first clock of a start bit; leaves on the first clock
   // after the stop bit. Checks the first and last clock of every bit.
   task automatic check_frame(input logic [7:0] b, input int per, input string tag);
      logic [9:0] bits;
      bits = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         chk({tag, "_bit_first"}, {31'd0, uart_tx}, {31'd0, bits[i]});
         chk({tag, "_done_low"}, {31'd0, tx_done}, 32'd0);
         tick(per - 1);
         chk({tag, "_bit_last"}, {31'd0, uart_tx}, {31'd0, bits[i]});
         if (i == 9) chk({tag, "_done_pulse"}, {31'd0, tx_done}, 32'd1);
         tick(1);
      end
   endtask

   initial begin
      reset    = 1'b1;
      baud_set = 3'd4;
      wr_data  = 8'h00;
      wr_en    = 1'b0;
      tick(3);
      chk("rst_uart_tx",    {31'd0, uart_tx},    32'd1);
      chk("rst_tx_busy",    {31'd0, tx_busy},    32'd0);
      chk("rst_tx_done",    {31'd0, tx_done},    32'd0);
      chk("rst_full",       {31'd0, full},       32'd0);
      chk("rst_overflow",   {31'd0, overflow},   32'd0);
      chk("rst_fifo_count", {27'd0, fifo_count}, 32'd0);
      reset = 1'b0;
      tick(2);

      // Single 0x55 frame at 115200 baud.
      wr_data = 8'h55; wr_en = 1'b1; tick; wr_en = 1'b0;
      chk("t1_cnt_written", {27'd0, fifo_count}, 32'd1);
      chk("t1_line_idle",   {31'd0, uart_tx},    32'd1);
      tick;
      chk("t1_cnt_popped",  {27'd0, fifo_count}, 32'd0);
      chk("t1_line_still",  {31'd0, uart_tx},    32'd1);
      chk("t1_busy_pre",    {31'd0, tx_busy},    32'd0);
      tick;
      chk("t1_busy",        {31'd0, tx_busy},    32'd1);
      check_frame(8'h55, 434, "t1");
      chk("t1_busy_end",    {31'd0, tx_busy},    32'd0);
      chk("t1_line_end",    {31'd0, uart_tx},    32'd1);
      chk("t1_done_count",  done_cnt,            32'd1);

      // Three bytes back-to-back.
      wr_en = 1'b1;
      wr_data = 8'hA3; tick;
      wr_data = 8'h0F; tick;
      wr_data = 8'hFF; tick;
      wr_en = 1'b0;
      chk("t2_cnt_queued",  {27'd0, fifo_count}, 32'd2);
      check_frame(8'hA3, 434, "t2a");
      check_frame(8'h0F, 434, "t2b");
      check_frame(8'hFF, 434, "t2c");
      chk("t2_done_count",  done_cnt,            32'd4);
      chk("t2_busy_end",    {31'd0, tx_busy},    32'd0);

      // Burst of 17 fills the FIFO exactly; 18th write overflows.
      wr_en = 1'b1;
      for (int i = 0; i < 17; i++) begin
         wr_data = 8'h10 + 8'(i);
         tick;
      end
      chk("t3_cnt_full",    {27'd0, fifo_count}, 32'd16);
      chk("t3_full",        {31'd0, full},       32'd1);
      chk("t3_no_ovf",      {31'd0, overflow},   32'd0);
      wr_data = 8'hEE; tick;
      chk("t3_ovf_pulse",   {31'd0, overflow},   32'd1);
      chk("t3_cnt_hold",    {27'd0, fifo_count}, 32'd16);
      wr_en = 1'b0; tick;
      chk("t3_ovf_clear",   {31'd0, overflow},   32'd0);
      // Line up a write with the pop at the end of the first frame's stop bit.
      tick(4322);
      chk("t6_cnt_before",  {27'd0, fifo_count}, 32'd16);
      wr_data = 8'h77; wr_en = 1'b1; tick; wr_en = 1'b0;
      chk("t6_ovf_pulse",   {31'd0, overflow},   32'd1);
      chk("t6_cnt_after",   {27'd0, fifo_count}, 32'd15);
      chk("t6_done_pulse",  {31'd0, tx_done},    32'd1);
      tick;
      chk("t6_next_start",  {31'd0, uart_tx},    32'd0);
      chk("t6_ovf_count",   ovf_cnt,             32'd2);

      // Asynchronous reset during a start bit drops the line high at once.
      reset = 1'b1; #2;
      chk("r1_line_high",   {31'd0, uart_tx},    32'd1);
      chk("r1_fifo_empty",  {27'd0, fifo_count}, 32'd0);
      chk("r1_busy",        {31'd0, tx_busy},    32'd0);
      chk("r1_full",        {31'd0, full},       32'd0);
      tick(3);
      reset = 1'b0;
      tick(2);

      // Reset in data bit 3 of 0x3C with another byte queued.
      d0 = done_cnt;
      wr_en = 1'b1;
      wr_data = 8'h3C; tick;
      wr_data = 8'h81; tick;
      wr_en = 1'b0; tick;
      chk("t5_start_low",   {31'd0, uart_tx},    32'd0);
      chk("t5_cnt_queued",  {27'd0, fifo_count}, 32'd1);
      tick(4 * 434 + 200);
      chk("t5_bit3",        {31'd0, uart_tx},    32'd1);
      chk("t5_busy",        {31'd0, tx_busy},    32'd1);
      reset = 1'b1; #2;
      chk("t5_line_high",   {31'd0, uart_tx},    32'd1);
      chk("t5_fifo_empty",  {27'd0, fifo_count}, 32'd0);
      chk("t5_busy_rst",    {31'd0, tx_busy},    32'd0);
      chk("t5_done_rst",    {31'd0, tx_done},    32'd0);
      tick(5);
      reset = 1'b0;
      tick(3);
      chk("t5_idle_line",   {31'd0, uart_tx},    32'd1);
      chk("t5_idle_busy",   {31'd0, tx_busy},    32'd0);
      chk("t5_no_done",     done_cnt,            d0);
      wr_data = 8'hC5; wr_en = 1'b1; tick; wr_en = 1'b0;
      tick(2);
      check_frame(8'hC5, 434, "t5");
      chk("t5_done_count",  done_cnt,            d0 + 1);

      // 9600-baud frame; the rate change mid-frame applies to the next one.
      baud_set = 3'd0;
      wr_en = 1'b1;
      wr_data = 8'h96; tick;
      wr_data = 8'h5A; tick;
      wr_en = 1'b0; tick;
      baud_set = 3'd4;
      chk("t4_cnt_queued",  {27'd0, fifo_count}, 32'd1);
      check_frame(8'h96, 5208, "t4a");
      check_frame(8'h5A, 434, "t4b");
      chk("t4_done_count",  done_cnt,            d0 + 3);
      chk("t4_busy_end",    {31'd0, tx_busy},    32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
